// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
//   Round-robin arbiter sharing one UART transmitter among NUM_REQ byte
//   producers. The winner's byte is latched onto tx_data and a one-cycle
//   tx_start is issued. Further grants are then held off for one frame time
//   plus an inter-frame guard time.
//
//   Optional feature macro: UART_SCHED_PRIO0_EN
//     defined   -> requester 0 has strict priority and does not move the rr
//                  pointer; requesters 1..N-1 rotate among themselves
//     undefined -> pure round-robin across all requesters
//
// Ports
//   clk       in   system clock, rising edge
//   reset     in   asynchronous active-low reset
//   req       in   [NUM_REQ]   level request per producer, held until ack
//   data_in   in   [NUM_REQ*8] packed bytes, requester k on [8k+7:8k]
//   ack       out  [NUM_REQ]   one-hot one-cycle accept pulse
//   tx_data   out  [8]         byte presented to the transmitter
//   tx_start  out  1           one-cycle frame start strobe
//   busy      out  1           high during LOAD/frame/guard
//   grant_id  out  [GW]        index of the last granted requester
module uart_tx_scheduler #(
    parameter int NUM_REQ      = 4,
    parameter int CLKS_PER_BIT = 5208,
    parameter int FRAME_BITS   = 11,
    parameter int GUARD_BITS   = 1,
    localparam int GW          = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*8-1:0] data_in,
    output logic [NUM_REQ-1:0]   ack,
    output logic [7:0]           tx_data,
    output logic                 tx_start,
    output logic                 busy,
    output logic [GW-1:0]        grant_id
);

    localparam logic [31:0] FRAME_CYC = 32'(CLKS_PER_BIT * FRAME_BITS);
    localparam logic [31:0] GUARD_CYC = 32'(CLKS_PER_BIT * GUARD_BITS);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_GUARD} state_t;

    state_t          state_q, state_d;
    logic [31:0]     cnt_q, cnt_d;
    logic [GW-1:0]   ptr_q, ptr_d;
    logic [GW-1:0]   gid_q, gid_d;
    logic [7:0]      txd_q, txd_d;

    logic [GW-1:0]   win;
    logic            found;
    int              idx;

    // First set req bit searching upward from ptr_q, wrapping modulo NUM_REQ.
    // The inner j loop keeps every req/data select constant-indexed.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!found && (j == idx) && req[j]) begin
                    found = 1'b1;
                    win   = GW'(j);
                end
            end
        end
`ifdef UART_SCHED_PRIO0_EN
        if (req[0]) win = '0;
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        gid_d   = gid_q;
        txd_d   = txd_q;
        unique case (state_q)
            S_IDLE: begin
                if (|req) begin
                    // Latch byte and id on entry so they are visible during LOAD.
                    gid_d = win;
                    for (int j = 0; j < NUM_REQ; j++)
                        if (win == GW'(j)) txd_d = data_in[j*8 +: 8];
                    // Counter starts here so LOAD itself is the first frame cycle.
                    cnt_d   = FRAME_CYC - 32'd1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
`ifdef UART_SCHED_PRIO0_EN
                if (gid_q != '0)
`endif
                begin
                    if (int'(gid_q) == NUM_REQ - 1) ptr_d = '0;
                    else                            ptr_d = gid_q + 1'b1;
                end
                if (cnt_q == 32'd0) begin
                    if (GUARD_CYC != 32'd0) begin
                        cnt_d   = GUARD_CYC - 32'd1;
                        state_d = S_GUARD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d   = cnt_q - 32'd1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 32'd0) begin
                    if (GUARD_CYC != 32'd0) begin
                        cnt_d   = GUARD_CYC - 32'd1;
                        state_d = S_GUARD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            S_GUARD: begin
                if (cnt_q == 32'd0) state_d = S_IDLE;
                else                cnt_d   = cnt_q - 32'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            gid_q   <= '0;
            txd_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            txd_q   <= txd_d;
        end
    end

    // Strobes decode straight from state so reset clears them immediately.
    always_comb begin
        ack = '0;
        for (int j = 0; j < NUM_REQ; j++)
            ack[j] = (state_q == S_LOAD) && (gid_q == GW'(j));
    end

    assign tx_start = (state_q == S_LOAD);
    assign busy     = (state_q != S_IDLE);
    assign tx_data  = txd_q;
    assign grant_id = gid_q;

endmodule
